// File: rtl/branch_pkg.sv
// Shared constants for the ID-stage branch path: opcodes (also used by the
// branch resolver), controller FSM encoding, and the stats counter width.
package branch_pkg;

   localparam logic [5:0] BEQ  = 6'b000100;
   localparam logic [5:0] BNE  = 6'b000101;
   localparam logic [5:0] JUMP = 6'b000010;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_STALL = 2'd1,
      S_REDIR = 2'd2
   } br_state_t;

   localparam int STATS_W = 16;

   // Saturating increment for the optional statistics counters.
   function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
      return (v == '1) ? v : v + STATS_W'(1);
   endfunction

endpackage

// File: rtl/branch_hazard_det.sv
// Pure combinational decode, operand-hazard and MEM-forward selection for an
// ID-stage comparator. Shared with the load-use unit, so it holds no state.
module branch_hazard_det
   import branch_pkg::*;
#(
   parameter int REG_W = 5
) (
   input  logic             i_id_valid,
   input  logic [5:0]       i_id_opcode,
   input  logic [REG_W-1:0] i_id_rs,
   input  logic [REG_W-1:0] i_id_rt,
   input  logic             i_ex_regwrite,
   input  logic [REG_W-1:0] i_ex_rd,
   input  logic             i_mem_regwrite,
   input  logic             i_mem_memread,
   input  logic [REG_W-1:0] i_mem_rd,
   output logic             o_is_cond,
   output logic             o_is_jump,
   output logic             o_hazard,
   output logic             o_fwd_a,
   output logic             o_fwd_b
);

   logic w_rs_nz;
   logic w_rt_nz;
   logic w_ex_hit;
   logic w_mem_load_hit;
   logic w_mem_alu;

   assign o_is_cond = i_id_valid & ((i_id_opcode == BEQ) | (i_id_opcode == BNE));
   assign o_is_jump = i_id_valid & (i_id_opcode == JUMP);

   // Register 0 is hard-wired, so it never creates a dependency.
   assign w_rs_nz = |i_id_rs;
   assign w_rt_nz = |i_id_rt;

   assign w_ex_hit = i_ex_regwrite &
                     ((w_rs_nz & (i_ex_rd == i_id_rs)) |
                      (w_rt_nz & (i_ex_rd == i_id_rt)));

   assign w_mem_load_hit = i_mem_regwrite & i_mem_memread &
                           ((w_rs_nz & (i_mem_rd == i_id_rs)) |
                            (w_rt_nz & (i_mem_rd == i_id_rt)));

   assign o_hazard = o_is_cond & (w_ex_hit | w_mem_load_hit);

   assign w_mem_alu = o_is_cond & i_mem_regwrite & ~i_mem_memread & (|i_mem_rd);
   assign o_fwd_a   = w_mem_alu & (i_mem_rd == i_id_rs);
   assign o_fwd_b   = w_mem_alu & (i_mem_rd == i_id_rt);

endmodule

// File: rtl/branch_ctrl.sv
// Branch sequencing controller: stalls on operand hazards, selects MEM forwarding,
// captures the resolver result and issues a one-cycle PC redirect with IF/ID flush.
// Optional statistics counters are enabled by defining BRANCH_CTRL_STATS_EN.
module branch_ctrl
   import branch_pkg::*;
#(
   parameter int PC_WIDE = 7,
   parameter int REG_W   = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               hold,
   input  logic               id_valid,
   input  logic [5:0]         id_opcode,
   input  logic [REG_W-1:0]   id_rs,
   input  logic [REG_W-1:0]   id_rt,
   input  logic               ex_regwrite,
   input  logic [REG_W-1:0]   ex_rd,
   input  logic               mem_regwrite,
   input  logic               mem_memread,
   input  logic [REG_W-1:0]   mem_rd,
   input  logic               br_taken,
   input  logic [PC_WIDE-1:0] br_pc,
   output logic               fwd_a,
   output logic               fwd_b,
   output logic               stall,
   output logic               pc_load,
   output logic [PC_WIDE-1:0] pc_target,
   output logic               flush_ifid
`ifdef BRANCH_CTRL_STATS_EN
   ,
   output logic [STATS_W-1:0] br_cnt,
   output logic [STATS_W-1:0] br_taken_cnt,
   output logic [STATS_W-1:0] stall_cnt
`endif
);

   br_state_t          r_state;
   logic [PC_WIDE-1:0] r_pc_target;
   logic               r_pc_load;
   logic               r_flush_ifid;

   logic w_is_cond;
   logic w_is_jump;
   logic w_hazard;
   logic w_fwd_a;
   logic w_fwd_b;
   logic w_in_redir;
   logic w_stall;
   logic w_resolve;
   logic w_redirect;

   branch_hazard_det #(
      .REG_W (REG_W)
   ) u_hazard_det (
      .i_id_valid     (id_valid),
      .i_id_opcode    (id_opcode),
      .i_id_rs        (id_rs),
      .i_id_rt        (id_rt),
      .i_ex_regwrite  (ex_regwrite),
      .i_ex_rd        (ex_rd),
      .i_mem_regwrite (mem_regwrite),
      .i_mem_memread  (mem_memread),
      .i_mem_rd       (mem_rd),
      .o_is_cond      (w_is_cond),
      .o_is_jump      (w_is_jump),
      .o_hazard       (w_hazard),
      .o_fwd_a        (w_fwd_a),
      .o_fwd_b        (w_fwd_b)
   );

   // In REDIR the ID stage holds a wrong-path instruction, so it is ignored.
   assign w_in_redir = (r_state == S_REDIR);
   assign w_stall    = ~w_in_redir & w_hazard;
   assign w_resolve  = ~w_in_redir & ~w_hazard & (w_is_cond | w_is_jump);
   assign w_redirect = w_resolve & br_taken;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge values; blocking here would create order-dependent simulation.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_pc_target  <= '0;
         r_pc_load    <= 1'b0;
         r_flush_ifid <= 1'b0;
      end else if (!hold) begin
         r_pc_load    <= 1'b0;
         r_flush_ifid <= 1'b0;
         unique case (r_state)
            S_IDLE, S_STALL: begin
               if ((r_state == S_STALL) && !id_valid) begin
                  r_state <= S_IDLE;
               end else if (w_hazard) begin
                  r_state <= S_STALL;
               end else if (w_redirect) begin
                  r_state      <= S_REDIR;
                  r_pc_target  <= br_pc;
                  r_pc_load    <= 1'b1;
                  r_flush_ifid <= 1'b1;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_REDIR: r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Combinational outputs are masked while reset is asserted.
   assign stall      = rst & w_stall;
   assign fwd_a      = rst & ~w_in_redir & w_fwd_a;
   assign fwd_b      = rst & ~w_in_redir & w_fwd_b;
   assign pc_load    = r_pc_load;
   assign flush_ifid = r_flush_ifid;
   assign pc_target  = r_pc_target;

`ifdef BRANCH_CTRL_STATS_EN
   logic [STATS_W-1:0] r_br_cnt;
   logic [STATS_W-1:0] r_br_taken_cnt;
   logic [STATS_W-1:0] r_stall_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_br_cnt       <= '0;
         r_br_taken_cnt <= '0;
         r_stall_cnt    <= '0;
      end else if (!hold) begin
         if (w_resolve)  r_br_cnt       <= sat_inc(r_br_cnt);
         if (w_redirect) r_br_taken_cnt <= sat_inc(r_br_taken_cnt);
         if (w_stall)    r_stall_cnt    <= sat_inc(r_stall_cnt);
      end
   end

   assign br_cnt       = r_br_cnt;
   assign br_taken_cnt = r_br_taken_cnt;
   assign stall_cnt    = r_stall_cnt;
`endif

endmodule
